// File: rtl/y86_regfile_pipe.sv
// Two-read/two-write Y86-64 register file with per-register pending-write counters for decode stalls.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module y86_regfile_pipe #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int ADDR_W = 4,
  parameter int RNONE  = 15,
  parameter int SP_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic              weE,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic              weM,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              iss_vld,
  input  logic [ADDR_W-1:0] iss_dstE,
  input  logic [ADDR_W-1:0] iss_dstM,
  output logic              stall,
  output logic              sb_err,
  output logic [DATA_W-1:0] rsp,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  localparam logic [ADDR_W-1:0] RNONE_A = ADDR_W'(RNONE);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [1:0]        cnt_q  [NREGS];
  logic [1:0]        cnt_d  [NREGS];
  logic              sb_err_q, sb_err_d;
  logic [NREGS-1:0]  inc_v, dec_v;
  logic              we_e, we_m, iss_e, iss_m;
  logic              stall_a, stall_b;

  function automatic logic legal(input logic [ADDR_W-1:0] idx);
    return (idx != RNONE_A) && (int'(idx) < NREGS);
  endfunction

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] idx);
    return legal(idx) ? regs_q[idx] : '0;
  endfunction

  function automatic logic [1:0] cnt_at(input logic [ADDR_W-1:0] idx);
    return legal(idx) ? cnt_q[idx] : 2'd0;
  endfunction

  // Ports are masked during reset so nothing leaks through the bypass path either.
  assign we_e  = weE && legal(dstE) && !rst;
  assign we_m  = weM && legal(dstM) && !rst;
  assign iss_e = iss_vld && legal(iss_dstE) && !rst;
  assign iss_m = iss_vld && legal(iss_dstM) && !rst;

  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    inc_v    = '0;
    dec_v    = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (we_e && dstE == ADDR_W'(i)) regs_d[i] = valE;
      if (we_m && dstM == ADDR_W'(i)) regs_d[i] = valM;
      // A register named by both ports only counts once in either direction.
      inc_v[i] = (iss_e && iss_dstE == ADDR_W'(i)) || (iss_m && iss_dstM == ADDR_W'(i));
      dec_v[i] = (we_e && dstE == ADDR_W'(i)) || (we_m && dstM == ADDR_W'(i));
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == 2'd3) sb_err_d = 1'b1;
        else                  cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == 2'd0) sb_err_d = 1'b1;
        else                  cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(i);
        cnt_q[i]  <= 2'd0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  function automatic logic wr_hit(input logic [ADDR_W-1:0] idx);
    return (we_e && dstE == idx) || (we_m && dstM == idx);
  endfunction

  function automatic logic [DATA_W-1:0] rd_byp(input logic [ADDR_W-1:0] idx);
    if (we_m && dstM == idx) return valM;
    if (we_e && dstE == idx) return valE;
    return rd(idx);
  endfunction

  assign valA    = rd_byp(srcA);
  assign valB    = rd_byp(srcB);
  // The last outstanding write landing this cycle is already forwarded, so no stall.
  assign stall_a = (cnt_at(srcA) != 2'd0) && !(cnt_at(srcA) == 2'd1 && wr_hit(srcA));
  assign stall_b = (cnt_at(srcB) != 2'd0) && !(cnt_at(srcB) == 2'd1 && wr_hit(srcB));
`else
  assign valA    = rd(srcA);
  assign valB    = rd(srcB);
  assign stall_a = cnt_at(srcA) != 2'd0;
  assign stall_b = cnt_at(srcB) != 2'd0;
`endif

  assign stall   = stall_a || stall_b;
  assign sb_err  = sb_err_q;
  assign rsp     = regs_q[SP_IDX];
  assign dbg_val = rd(dbg_sel);

endmodule

// File: tb/tb_y86_regfile_pipe.sv
// Randomized and directed bench for y86_regfile_pipe against a set-based behavioural model.
module tb_y86_regfile_pipe;

  localparam int DW = 64;
  localparam int NR = 15;
  localparam int AW = 4;
  localparam int RN = 15;
  localparam int SP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] srcA, srcB, dstE, dstM, iss_dstE, iss_dstM, dbg_sel;
  logic [DW-1:0] valA, valB, valE, valM, rsp, dbg_val;
  logic          weE, weM, iss_vld, stall, sb_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_reg [NR];
  int            m_cnt [NR];
  bit            m_err;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  y86_regfile_pipe #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .RNONE(RN), .SP_IDX(SP)) dut (
    .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .weE(weE), .dstE(dstE), .valE(valE), .weM(weM), .dstM(dstM), .valM(valM),
    .iss_vld(iss_vld), .iss_dstE(iss_dstE), .iss_dstM(iss_dstM),
    .stall(stall), .sb_err(sb_err), .rsp(rsp), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit lg(input int idx);
    return idx != RN && idx < NR;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = DW'(i);
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit writes_to(input int idx);
    if (rst || !lg(idx)) return 1'b0;
    return (weE && lg(int'(dstE)) && int'(dstE) == idx) || (weM && lg(int'(dstM)) && int'(dstM) == idx);
  endfunction

  function automatic logic [DW-1:0] exp_val(input int idx);
    if (!lg(idx)) return '0;
    if (BYP && !rst) begin
      if (weM && int'(dstM) == idx) return valM;
      if (weE && int'(dstE) == idx) return valE;
    end
    return m_reg[idx];
  endfunction

  function automatic bit exp_src_stall(input int idx);
    if (!lg(idx) || m_cnt[idx] == 0) return 1'b0;
    if (BYP && m_cnt[idx] == 1 && writes_to(idx)) return 1'b0;
    return 1'b1;
  endfunction

  // Applies one clock edge: writes in port order (M last wins), then net counter movement per register.
  function automatic void model_step();
    bit inc [NR];
    bit dec [NR];
    for (int r = 0; r < NR; r++) begin
      inc[r] = 1'b0;
      dec[r] = 1'b0;
    end
    if (weE && lg(int'(dstE))) begin m_reg[dstE] = valE; dec[dstE] = 1'b1; end
    if (weM && lg(int'(dstM))) begin m_reg[dstM] = valM; dec[dstM] = 1'b1; end
    if (iss_vld && lg(int'(iss_dstE))) inc[iss_dstE] = 1'b1;
    if (iss_vld && lg(int'(iss_dstM))) inc[iss_dstM] = 1'b1;
    for (int r = 0; r < NR; r++) begin
      int delta;
      delta = int'(inc[r]) - int'(dec[r]);
      if (delta > 0) begin
        if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r]++;
      end else if (delta < 0) begin
        if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
      end
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    chk("valA", valA, exp_val(int'(srcA)));
    chk("valB", valB, exp_val(int'(srcB)));
    chk("rsp", rsp, m_reg[SP]);
    chk("dbg_val", dbg_val, lg(int'(dbg_sel)) ? m_reg[dbg_sel] : '0);
    chk("stall", DW'(stall), DW'(exp_src_stall(int'(srcA)) || exp_src_stall(int'(srcB))));
    chk("sb_err", DW'(sb_err), DW'(m_err));
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; srcA = 4'd3; srcB = 4'd14; dbg_sel = 4'(RN);
    weE = 0; dstE = 0; valE = 0; weM = 0; dstM = 0; valM = 0;
    iss_vld = 0; iss_dstE = 4'(RN); iss_dstM = 4'(RN);
    model_reset();
    #2;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_valA", valA, 64'd3);
    chk("rst_valB", valB, 64'd14);
    chk("rst_rsp", rsp, 64'd4);
    chk("rst_stall", DW'(stall), '0);
    chk("rst_err", DW'(sb_err), '0);
    srcA = 4'(RN);
    #1 chk("rnone_valA", valA, '0);

    // M-over-E collision on register 2, after issuing it so the counter stays balanced
    iss_vld = 1; iss_dstE = 4'd2; iss_dstM = 4'(RN);
    cycle();
    iss_vld = 0;
    weE = 1; dstE = 4'd2; valE = 64'hAA; weM = 1; dstM = 4'd2; valM = 64'h55; srcA = 4'd2;
    #1 chk("coll_same_cycle", valA, BYP ? 64'h55 : 64'd2);
    cycle();
    weE = 0; weM = 0;
    #1;
    chk("coll_valA", valA, 64'h55);
    chk("coll_err", DW'(sb_err), '0);

    // Issue to 5, stall next cycle, cleared by a write
    iss_vld = 1; iss_dstE = 4'd5; iss_dstM = 4'(RN); srcA = 4'd5;
    #1 chk("iss_no_stall_now", DW'(stall), '0);
    cycle();
    iss_vld = 0;
    #1 chk("iss_stall", DW'(stall), 64'd1);
    weE = 1; dstE = 4'd5; valE = 64'h77;
    #1 chk("wr_cycle_stall", DW'(stall), BYP ? '0 : 64'd1);
    cycle();
    weE = 0;
    #1 chk("wr_stall_clr", DW'(stall), '0);

    // Overflow on register 6 then drain
    iss_vld = 1; iss_dstE = 4'd6; iss_dstM = 4'd6; srcA = 4'd6;
    repeat (4) cycle();
    iss_vld = 0;
    #1;
    chk("ovf_err", DW'(sb_err), 64'd1);
    chk("ovf_stall", DW'(stall), 64'd1);
    weE = 1; dstE = 4'd6; valE = 64'h66;
    repeat (3) cycle();
    weE = 0;
    #1;
    chk("drain_stall", DW'(stall), '0);
    chk("drain_err", DW'(sb_err), 64'd1);

    // Mid-cycle asynchronous reset
    weE = 1; dstE = 4'd9; valE = 64'h1234;
    cycle();
    weE = 0; srcA = 4'd9;
    #1 chk("w9_val", valA, 64'h1234);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_val9", valA, 64'd9);
    chk("arst_stall", DW'(stall), '0);
    chk("arst_err", DW'(sb_err), '0);
    cycle();
    rst = 1'b0;

    // Writes to RNONE / out-of-range are dropped without underflow
    weE = 1; dstE = 4'(RN); valE = 64'hDEAD; weM = 1; dstM = 4'd15; valM = 64'hBEEF;
    cycle();
    weE = 0; weM = 0;
    #1;
    chk("inv_err", DW'(sb_err), '0);
    chk("inv_val9", valA, 64'd9);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      srcA     = 4'($urandom_range(0, 15));
      srcB     = 4'($urandom_range(0, 15));
      dbg_sel  = 4'($urandom_range(0, 15));
      weE      = 1'($urandom_range(0, 1));
      dstE     = 4'($urandom_range(0, 15));
      valE     = {$urandom, $urandom};
      weM      = 1'($urandom_range(0, 1));
      dstM     = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
      valM     = {$urandom, $urandom};
      iss_vld  = 1'($urandom_range(0, 1));
      iss_dstE = 4'($urandom_range(0, 15));
      iss_dstM = ($urandom_range(0, 3) == 0) ? iss_dstE : 4'($urandom_range(0, 15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
